// File: rtl/cbya_seq_sub.sv
// cbya_seq_sub: multi-cycle carry-bypass subtractor.
// Computes diff = a - b (mod 2^WIDTH) as a + ~b + 1, one 8-bit carry-bypass
// block per clock, least-significant block first. A single carry register
// links consecutive blocks. Operands are latched on accept; the result is
// held in DONE until the downstream handshake completes.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake; a (minuend), b (subtrahend)
//   out_valid/out_ready result handshake
//   diff                a - b modulo 2^WIDTH
//   borrow_out          1 when a < b (unsigned)
//   overflow            signed two's-complement overflow
//   bypass_cnt          blocks whose carry took the bypass path
//
// Build option: define CBYA_SUB_BYPASS_STAT_EN to enable the bypass_cnt
// statistic; otherwise bypass_cnt is tied to 0.
//
// WIDTH must be a multiple of 8 and at least 8.
//
// state  | meaning
// S_IDLE | waiting for operands, in_ready = 1
// S_RUN  | processing block idx, one block per cycle
// S_DONE | result valid, waiting for out_ready

module cbya_seq_sub #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         diff,
  output logic                     borrow_out,
  output logic                     overflow,
  output logic [$clog2(WIDTH/8):0] bypass_cnt
);

  localparam int N  = WIDTH / 8;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             carry;

  logic [7:0] a_sl;
  logic [7:0] nb_sl;
  logic [7:0] sum;
  logic       rc;
  logic       byp;
  logic       cout;

  // One carry-bypass block on slice idx of the latched operands.
  // When every propagate bit is set the ripple carry equals carry_in anyway;
  // the bypass mux just gives the carry a short path.
  always_comb begin
    a_sl      = a_q[{idx, 3'b000} +: 8];
    nb_sl     = ~b_q[{idx, 3'b000} +: 8];
    {rc, sum} = 9'(a_sl) + 9'(nb_sl) + 9'(carry);
    byp       = &(a_sl ^ nb_sl);
    cout      = byp ? carry : rc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      idx        <= '0;
      carry      <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            idx      <= '0;
            carry    <= 1'b1;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          diff[{idx, 3'b000} +: 8] <= sum;
          carry                    <= cout;
          if (idx == IW'(N - 1)) begin
            // sum[7] is the final diff MSB being written this cycle.
            borrow_out <= ~cout;
            overflow   <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sum[7] ^ a_q[WIDTH-1]);
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CBYA_SUB_BYPASS_STAT_EN
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == S_IDLE && in_valid && in_ready) begin
      cnt <= '0;
    end else if (state == S_RUN && byp) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bypass_cnt = cnt;
`else
  assign bypass_cnt = '0;
`endif

endmodule

// File: tb/tb_cbya_seq_sub.sv
module tb_cbya_seq_sub;

  localparam int WIDTH = 32;
  localparam int N     = WIDTH / 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  diff;
  logic              borrow_out;
  logic              overflow;
  logic [2:0]        bypass_cnt;

  int checks   = 0;
  int failures = 0;

  cbya_seq_sub #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .bypass_cnt (bypass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int cnt_exp(input int n);
`ifdef CBYA_SUB_BYPASS_STAT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept operands, then scramble the inputs to show they were latched.
  task automatic accept(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = $urandom();
    b = $urandom();
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(N));
  endtask

  task automatic run_op(input string tag,
                        input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH-1:0] d_exp, input logic bo_exp,
                        input logic ov_exp, input int byp_exp);
    accept(av, bv);
    chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    wait_done(tag);
    chk({tag, "_diff"}, 64'(diff), 64'(d_exp));
    chk({tag, "_borrow"}, 64'(borrow_out), 64'(bo_exp));
    chk({tag, "_ovf"}, 64'(overflow), 64'(ov_exp));
    chk({tag, "_bypass"}, 64'(bypass_cnt), 64'(cnt_exp(byp_exp)));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_borrow", 64'(borrow_out), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_bypass", 64'(bypass_cnt), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();

    run_op("v5m3",  32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 3);
    run_op("v3m5",  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0, 3);
    run_op("vmin1", 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 2);
    run_op("veq",   32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 4);
    run_op("v0mff", 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 0);
    run_op("vmaxn", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 3);
    run_op("vbyp",  32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 2);

    // Backpressure hold with an ignored in_valid pulse.
    accept(32'h0000_FF10, 32'h0000_0F20);
    wait_done("hold");
    for (int i = 0; i < 10; i++) begin
      chk("hold_diff", 64'(diff), 64'h0000_EFF0);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      if (i == 4) begin
        a = 32'hDEAD_BEEF;
        b = 32'h0000_0001;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    chk("hold_borrow", 64'(borrow_out), 64'd0);
    chk("hold_ovf", 64'(overflow), 64'd0);
    chk("hold_bypass", 64'(bypass_cnt), 64'(cnt_exp(2)));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold_release_ready", 64'(in_ready), 64'd1);
    chk("hold_release_valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("hold_no_queued_op", 64'(seen), 64'd0);

    // Abort in the second RUN cycle.
    accept(32'h0000_0009, 32'h0000_0004);
    step();
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_diff", 64'(diff), 64'd0);
    chk("abort_bypass", 64'(bypass_cnt), 64'd0);
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    run_op("v7m7", 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b0, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
